// File: rtl/vmask_pack_issue.sv
// Mask-reduction front end. It issues one read per mask pack and forwards each
// returned pack, ANDed with v0 and with the tail mask, to the first/popcount stage.
module vmask_pack_issue #(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int IDX_BITS        = 10,
  parameter int ADDR_WIDTH      = 32,
  parameter int VL_BITS         = IDX_BITS + DATA_WIDTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VL_BITS-1:0]    req_vl,
  input  logic                  req_vm,
  input  logic                  req_opSel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rd_en,
  output logic [IDX_BITS-1:0]   rd_idx,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_vs2,
  input  logic [DATA_WIDTH-1:0] rd_v0,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_m0,
  output logic [IDX_BITS-1:0]   out_start_idx,
  output logic                  out_end,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_opSel,
  output logic                  busy
);

  localparam int CNT_BITS = IDX_BITS + 1;
  localparam int VLR_BITS = VL_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [2:0] GAP_LAST = 3'd4;

  logic [1:0]                 state;
  logic                       init_done;
  logic [DATA_WIDTH_BITS-1:0] vl_rem_q;
  logic                       vm_q;
  logic                       opsel_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [CNT_BITS-1:0]        n_q;
  logic [CNT_BITS-1:0]        issue_cnt;
  logic [CNT_BITS-1:0]        ret_cnt;
  logic [2:0]                 gap_cnt;

  logic                       accept;
  logic                       req_zero;
  logic [VLR_BITS-1:0]        vl_round;
  logic [CNT_BITS-1:0]        n_accept;
  logic                       ret_ok;
  logic                       ret_last;
  logic [DATA_WIDTH-1:0]      tail;
  logic [DATA_WIDTH-1:0]      m0;

  // Counters are one bit wider than the index so N = 2^IDX_BITS never wraps.
  assign req_ready = init_done & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_zero  = (req_vl == '0);
  assign vl_round  = {1'b0, req_vl} + VLR_BITS'(DATA_WIDTH - 1);
  assign n_accept  = req_zero ? CNT_BITS'(1) : CNT_BITS'(vl_round >> DATA_WIDTH_BITS);

  assign rd_en  = (state == ISSUE);
  assign rd_idx = rd_en ? issue_cnt[IDX_BITS-1:0] : '0;
  assign busy   = (state != IDLE);

  assign ret_ok   = rd_valid & ((state == ISSUE) | (state == WAIT)) & (ret_cnt < n_q);
  assign ret_last = (ret_cnt == n_q - CNT_BITS'(1));

  always_comb begin
    tail = {DATA_WIDTH{1'b1}};
    if (ret_last && (vl_rem_q != '0)) begin
      tail = ~({DATA_WIDTH{1'b1}} << vl_rem_q);
    end
    m0 = rd_vs2 & (vm_q ? {DATA_WIDTH{1'b1}} : rd_v0) & tail;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      init_done <= 1'b0;
      vl_rem_q  <= '0;
      vm_q      <= 1'b0;
      opsel_q   <= 1'b0;
      addr_q    <= '0;
      n_q       <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            vl_rem_q  <= req_vl[DATA_WIDTH_BITS-1:0];
            vm_q      <= req_vm;
            opsel_q   <= req_opSel;
            addr_q    <= req_addr;
            n_q       <= n_accept;
            issue_cnt <= '0;
            // An empty operation is emitted straight from IDLE with no reads.
            if (req_zero) begin
              ret_cnt <= CNT_BITS'(1);
              state   <= WAIT;
            end else begin
              ret_cnt <= '0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + CNT_BITS'(1);
          if (issue_cnt == n_q - CNT_BITS'(1)) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (out_valid && out_end) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
      endcase
      if (ret_ok) begin
        ret_cnt <= ret_cnt + CNT_BITS'(1);
      end
    end
  end

  // Output stage is fully registered and forced to zero whenever no pack is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_m0        <= '0;
      out_start_idx <= '0;
      out_end       <= 1'b0;
      out_addr      <= '0;
      out_opSel     <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_m0        <= '0;
      out_start_idx <= '0;
      out_end       <= 1'b0;
      out_addr      <= '0;
      out_opSel     <= 1'b0;
      if (accept && req_zero) begin
        out_valid <= 1'b1;
        out_end   <= 1'b1;
        out_addr  <= req_addr;
        out_opSel <= req_opSel;
      end else if (ret_ok) begin
        out_valid     <= 1'b1;
        out_m0        <= m0;
        out_start_idx <= ret_cnt[IDX_BITS-1:0];
        out_end       <= ret_last;
        out_addr      <= addr_q;
        out_opSel     <= opsel_q;
      end
    end
  end

endmodule
